// File: rtl/apb_master_arbiter_if.sv
// Bundle of the two requester ports and the shared APB bus of the arbiter.
// master = arbiter side, slave = requesters plus APB slave side.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master: SETUP/ACCESS sequencing, PREADY wait
// with timeout abort, and a one-cycle ACK/ERR/RDATA response to the winner.
module apb_master_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK_i,
    input  logic                   PRESET_i,
    apb_master_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              last_reg;
    logic              grant_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic              win_next;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_data;

    always_comb begin
        // Under contention the requester not granted last time wins.
        win_next = bus.req1;
        if (bus.req0 && bus.req1)
            win_next = ~last_reg;
        win_wr    = win_next ? bus.wr1    : bus.wr0;
        win_addr  = win_next ? bus.addr1  : bus.addr0;
        win_wdata = win_next ? bus.wdata1 : bus.wdata0;
        // PREADY takes priority over a timeout firing on the same edge.
        done      = bus.pready || (cnt_reg == CNT_LAST);
        done_err  = ~bus.pready;
        done_data = (bus.pready && !pwrite_reg) ? bus.prdata : '0;
    end

    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            last_reg     <= 1'b1;
            grant_reg    <= 1'b0;
            psel_reg     <= 1'b0;
            penable_reg  <= 1'b0;
            pwrite_reg   <= 1'b0;
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            ack_reg      <= '0;
            err_reg      <= '0;
            rdata_reg[0] <= '0;
            rdata_reg[1] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        grant_reg  <= win_next;
                        last_reg   <= win_next;
                        pwrite_reg <= win_wr;
                        paddr_reg  <= win_addr;
                        pwdata_reg <= win_wdata;
                        psel_reg   <= 1'b1;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    cnt_reg     <= '0;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        psel_reg             <= 1'b0;
                        penable_reg          <= 1'b0;
                        ack_reg[grant_reg]   <= 1'b1;
                        err_reg[grant_reg]   <= done_err;
                        rdata_reg[grant_reg] <= done_data;
                        state_reg            <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RESP: begin
                    ack_reg      <= '0;
                    err_reg      <= '0;
                    rdata_reg[0] <= '0;
                    rdata_reg[1] <= '0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.psel    = psel_reg;
    assign bus.penable = penable_reg;
    assign bus.pwrite  = pwrite_reg;
    assign bus.paddr   = paddr_reg;
    assign bus.pwdata  = pwdata_reg;
    assign bus.ack0    = ack_reg[0];
    assign bus.ack1    = ack_reg[1];
    assign bus.err0    = err_reg[0];
    assign bus.err1    = err_reg[1];
    assign bus.rdata0  = rdata_reg[0];
    assign bus.rdata1  = rdata_reg[1];
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: write, read, contention, timeout,
// PREADY/timeout tie, TIMEOUT=1 abort and asynchronous reset mid-transfer.
module tb_apb_master_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apb_master_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    apb_master_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

    apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .PCLK_i   (clk),
        .PRESET_i (rst),
        .bus      (bus.master)
    );

    apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(1)) dut_t1 (
        .PCLK_i   (clk),
        .PRESET_i (rst),
        .bus      (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_addr [4];

    initial begin
        checks = 0;
        errors = 0;
        exp_addr = '{8'h10, 8'h21, 8'h10, 8'h21};
        rst = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.prdata = 0; bus.pready = 0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.wr0 = 0; bus1.wr1 = 0;
        bus1.addr0 = 0; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;
        bus1.prdata = 0; bus1.pready = 0;
        #1;
        check("rst_psel", 32'(bus.psel), 32'd0);
        check("rst_penable", 32'(bus.penable), 32'd0);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_paddr", 32'(bus.paddr), 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Single write, one wait state; PREADY high during SETUP must be ignored.
        bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 8'h03; bus.wdata0 = 8'hA5;
        tick();
        check("wr_setup_psel", 32'(bus.psel), 32'd1);
        check("wr_setup_penable", 32'(bus.penable), 32'd0);
        check("wr_paddr", 32'(bus.paddr), 32'h03);
        check("wr_pwdata", 32'(bus.pwdata), 32'hA5);
        check("wr_pwrite", 32'(bus.pwrite), 32'd1);
        bus.pready = 1;
        tick();
        check("wr_access_penable", 32'(bus.penable), 32'd1);
        check("wr_access_psel", 32'(bus.psel), 32'd1);
        bus.pready = 0;
        tick();
        check("wr_wait_penable", 32'(bus.penable), 32'd1);
        check("wr_wait_ack0", 32'(bus.ack0), 32'd0);
        bus.pready = 1;
        tick();
        check("wr_ack0", 32'(bus.ack0), 32'd1);
        check("wr_err0", 32'(bus.err0), 32'd0);
        check("wr_rdata0", 32'(bus.rdata0), 32'd0);
        check("wr_ack1", 32'(bus.ack1), 32'd0);
        check("wr_resp_psel", 32'(bus.psel), 32'd0);
        check("wr_resp_penable", 32'(bus.penable), 32'd0);
        bus.req0 = 0; bus.pready = 0;
        tick();
        check("wr_ack0_drop", 32'(bus.ack0), 32'd0);

        // Single read from requester 1, zero-wait slave.
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 8'h05; bus.prdata = 8'h3C; bus.pready = 1;
        tick();
        check("rd_paddr", 32'(bus.paddr), 32'h05);
        check("rd_pwrite", 32'(bus.pwrite), 32'd0);
        tick();
        check("rd_penable", 32'(bus.penable), 32'd1);
        tick();
        check("rd_ack1", 32'(bus.ack1), 32'd1);
        check("rd_rdata1", 32'(bus.rdata1), 32'h3C);
        check("rd_err1", 32'(bus.err1), 32'd0);
        check("rd_ack0", 32'(bus.ack0), 32'd0);
        bus.req1 = 0;
        tick();
        check("rd_ack1_drop", 32'(bus.ack1), 32'd0);
        check("rd_rdata1_drop", 32'(bus.rdata1), 32'd0);

        // Contention: both held for four transfers, expect grants 0,1,0,1.
        bus.req0 = 1; bus.req1 = 1; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = 8'h10; bus.addr1 = 8'h21; bus.pready = 1;
        for (int i = 0; i < 4; i++) begin
            bus.prdata = 8'(8'h40 + i);
            tick();
            check($sformatf("cont%0d_paddr", i), 32'(bus.paddr), 32'(exp_addr[i]));
            tick();
            tick();
            check($sformatf("cont%0d_ack0", i), 32'(bus.ack0), 32'((i % 2) == 0));
            check($sformatf("cont%0d_ack1", i), 32'(bus.ack1), 32'((i % 2) == 1));
            check($sformatf("cont%0d_rdata", i),
                  32'((i % 2) == 0 ? bus.rdata0 : bus.rdata1), 32'(8'h40 + i));
            if (i == 3) begin
                bus.req0 = 0; bus.req1 = 0;
            end
            tick();
        end

        // Timeout: PREADY held low for the full 16 ACCESS cycles.
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 8'h07; bus.prdata = 8'hEE; bus.pready = 0;
        tick();
        tick();
        check("to_access_penable", 32'(bus.penable), 32'd1);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check($sformatf("to_cycle%0d_penable", c), 32'(bus.penable), 32'd1);
            check($sformatf("to_cycle%0d_ack0", c), 32'(bus.ack0), 32'd0);
        end
        tick();
        check("to_ack0", 32'(bus.ack0), 32'd1);
        check("to_err0", 32'(bus.err0), 32'd1);
        check("to_rdata0", 32'(bus.rdata0), 32'd0);
        check("to_psel", 32'(bus.psel), 32'd0);
        check("to_penable", 32'(bus.penable), 32'd0);
        bus.req0 = 0;
        tick();

        // Tie: PREADY first high in the 16th ACCESS cycle.
        bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 8'h0A; bus.prdata = 8'h5A; bus.pready = 0;
        tick();
        tick();
        repeat (15) tick();
        check("tie_still_access", 32'(bus.penable), 32'd1);
        bus.pready = 1;
        tick();
        check("tie_ack1", 32'(bus.ack1), 32'd1);
        check("tie_err1", 32'(bus.err1), 32'd0);
        check("tie_rdata1", 32'(bus.rdata1), 32'h5A);
        bus.req1 = 0; bus.pready = 0;
        tick();

        // TIMEOUT=1 instance aborts after a single ACCESS cycle.
        bus1.req0 = 1; bus1.wr0 = 0; bus1.addr0 = 8'h02; bus1.prdata = 8'h99;
        tick();
        tick();
        check("t1_penable", 32'(bus1.penable), 32'd1);
        tick();
        check("t1_ack0", 32'(bus1.ack0), 32'd1);
        check("t1_err0", 32'(bus1.err0), 32'd1);
        check("t1_rdata0", 32'(bus1.rdata0), 32'd0);
        bus1.req0 = 0;
        tick();

        // Asynchronous reset during ACCESS, then pointer must favour requester 0.
        bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 8'h0C; bus.wdata0 = 8'h77; bus.pready = 0;
        tick();
        tick();
        check("rsta_pre_penable", 32'(bus.penable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rsta_psel", 32'(bus.psel), 32'd0);
        check("rsta_penable", 32'(bus.penable), 32'd0);
        check("rsta_ack0", 32'(bus.ack0), 32'd0);
        bus.req1 = 1; bus.addr1 = 8'h33; bus.wr1 = 0; bus.pready = 1;
        tick();
        check("rsta_hold_ack0", 32'(bus.ack0), 32'd0);
        rst = 1'b0;
        tick();
        check("rsta_regrant_paddr", 32'(bus.paddr), 32'h0C);
        tick();
        tick();
        check("rsta_ack0", 32'(bus.ack0), 32'd1);
        check("rsta_ack1", 32'(bus.ack1), 32'd0);
        check("rsta_err0", 32'(bus.err0), 32'd0);
        bus.req0 = 0; bus.req1 = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
